// File: rtl/control_sequencer.sv
// control_sequencer: single-step fetch/execute control sequencer.
// Walks IDLE -> T0..T5 and decodes per-register latch/drive strobes from the
// current state plus the opcode captured during T2. The program counter
// lives here and is exported zero-extended on pc_out.
// Optional build macro SEQ_ILLEGAL_TRAP_EN: opcodes 0x6..0xE halt with
// illegal=1. Without it they execute as NOP and illegal is tied low.
module control_sequencer #(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned OP_LSB = 12
) (
    input  logic             one_shot_clock,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      bus_in,
    input  logic             psw_zero,
    output logic [7:0]       latch,
    output logic [7:0]       enable,
    output logic             pc_enable,
    output logic [15:0]      pc_out,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_add,
    output logic             psw_update,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned R_GPR = 0;
    localparam int unsigned R_MDR = 1;
    localparam int unsigned R_IR  = 2;
    localparam int unsigned R_MAR = 4;
    localparam int unsigned R_Y   = 5;
    localparam int unsigned R_Z   = 6;

    localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h1;
    localparam logic [OP_W-1:0] OP_STORE = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OP_W-1:0] OP_JMP   = 4'h4;
    localparam logic [OP_W-1:0] OP_JZ    = 4'h5;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t          cur_state;
    logic [PC_W-1:0] pc;
    logic [OP_W-1:0] opcode;
    logic            unused_bus;

    // Only the opcode field and the jump-target bits of the bus are consumed.
    assign unused_bus = ^bus_in;

    assign state  = cur_state;
    assign pc_out = 16'(pc);

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // State, program counter, opcode and status registers.
    always_ff @(posedge one_shot_clock) begin
        if (reset) begin
            cur_state <= S_IDLE;
            pc        <= '0;
            opcode    <= '0;
            halted    <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (cur_state)
                S_IDLE: if (run) cur_state <= S_T0;
                S_T0:   cur_state <= S_T1;
                S_T1: begin
                    pc        <= pc + PC_W'(1);
                    cur_state <= S_T2;
                end
                S_T2: begin
                    opcode    <= bus_in[OP_LSB +: OP_W];
                    cur_state <= S_T3;
                end
                S_T3: begin
                    case (opcode)
                        OP_NOP:   cur_state <= S_T0;
                        OP_LOAD,
                        OP_STORE,
                        OP_ADD:   cur_state <= S_T4;
                        OP_JMP: begin
                            pc        <= bus_in[PC_W-1:0];
                            cur_state <= S_T0;
                        end
                        OP_JZ: begin
                            if (psw_zero) pc <= bus_in[PC_W-1:0];
                            cur_state <= S_T0;
                        end
                        OP_HALT: begin
                            halted    <= 1'b1;
                            cur_state <= S_HALT;
                        end
                        default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                            halted    <= 1'b1;
                            illegal_q <= 1'b1;
                            cur_state <= S_HALT;
`else
                            cur_state <= S_T0;
`endif
                        end
                    endcase
                end
                S_T4:   cur_state <= S_T5;
                S_T5:   cur_state <= S_T0;
                S_HALT: cur_state <= S_HALT;
                default: cur_state <= S_IDLE;
            endcase
        end
    end

    // Moore strobe decode; reset forces every strobe low in the same cycle.
    always_comb begin
        latch      = '0;
        enable     = '0;
        pc_enable  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_add    = 1'b0;
        psw_update = 1'b0;
        if (!reset) begin
            case (cur_state)
                S_T0: begin
                    pc_enable    = 1'b1;
                    latch[R_MAR] = 1'b1;
                end
                S_T1: begin
                    mem_read     = 1'b1;
                    latch[R_MDR] = 1'b1;
                end
                S_T2: begin
                    enable[R_MDR] = 1'b1;
                    latch[R_IR]   = 1'b1;
                end
                S_T3: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: begin
                            enable[R_IR] = 1'b1;
                            latch[R_MAR] = 1'b1;
                        end
                        OP_ADD: begin
                            enable[R_GPR] = 1'b1;
                            latch[R_Y]    = 1'b1;
                        end
                        OP_JMP: enable[R_IR] = 1'b1;
                        OP_JZ:  enable[R_IR] = psw_zero;
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (opcode)
                        OP_LOAD: begin
                            mem_read     = 1'b1;
                            latch[R_MDR] = 1'b1;
                        end
                        OP_STORE: begin
                            enable[R_GPR] = 1'b1;
                            latch[R_MDR]  = 1'b1;
                        end
                        OP_ADD: begin
                            enable[R_MDR] = 1'b1;
                            latch[R_Z]    = 1'b1;
                            alu_add       = 1'b1;
                            psw_update    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (opcode)
                        OP_LOAD: begin
                            enable[R_MDR] = 1'b1;
                            latch[R_GPR]  = 1'b1;
                        end
                        OP_STORE: mem_write = 1'b1;
                        OP_ADD: begin
                            enable[R_Z]  = 1'b1;
                            latch[R_GPR] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
